sonic_scheduler: RTL and testbench

SONIC_SCHEDULER -- requirements
Module: sonic_scheduler

---
 rtl/sonic_pkg.sv | 17 +
 rtl/sonic_echo_sync.sv | 35 +++
 rtl/sonic_scheduler.sv | 150 +++++++++++++++
 tb/tb_sonic_scheduler.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonic_pkg.sv
// Shared types and constants for the round-robin ultrasonic ranging scheduler.
`timescale 1ns/1ps
package sonic_pkg;

  localparam int DIST_W = 12;
  localparam logic [DIST_W-1:0] NO_ECHO_CM = 12'd4095;
  localparam logic [DIST_W-1:0] MAX_CM     = 12'd4094;

  typedef enum logic [2:0] {
    IDLE,
    TRIG,
    WAIT_RISE,
    MEASURE,
    GAP
  } state_t;

endpackage

// File: rtl/sonic_echo_sync.sv
// Two-flop synchronizer for the raw echo bus, followed by edge detection
// on the synchronized value.
`timescale 1ns/1ps
module sonic_echo_sync #(
  parameter int WIDTH = 4
) (
  input  logic             CLOCK_50,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] prev;

  // NOTE: every flop in a sequential block uses <= so the three stages shift
  // in lockstep instead of collapsing into one register.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/sonic_scheduler.sv
// Sequences NUM_SENSORS ultrasonic rangers: trigger pulse, echo-width
// measurement in cm via a prescaler, per-sensor timeout, and settle gap.
`timescale 1ns/1ps
module sonic_scheduler
  import sonic_pkg::*;
#(
  parameter int NUM_SENSORS    = 4,
  parameter int TRIG_CYCLES    = 500,
  parameter int CYC_PER_CM     = 2900,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GAP_CYCLES     = 3_000_000,
  localparam int IDX_W = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                          CLOCK_50,
  input  logic                          reset_n,
  input  logic                          enable,
  input  logic [NUM_SENSORS-1:0]        echo,
  output logic [NUM_SENSORS-1:0]        trigger,
  output logic [NUM_SENSORS*DIST_W-1:0] dist_cm,
  output logic [NUM_SENSORS-1:0]        timeout,
  output logic                          upd,
  output logic [IDX_W-1:0]              upd_idx,
  output logic                          busy
);

  localparam int PH_MAX = (GAP_CYCLES > TRIG_CYCLES) ? GAP_CYCLES : TRIG_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int PS_W   = $clog2(CYC_PER_CM + 1);

  state_t                 state;
  logic [IDX_W-1:0]       sel;
  logic [IDX_W-1:0]       sel_next;
  logic [PH_W-1:0]        phase_cnt;
  logic [TO_W-1:0]        to_cnt;
  logic [PS_W-1:0]        prescale;
  logic [DIST_W-1:0]      cm_count;
  logic [NUM_SENSORS-1:0] echo_rise;
  logic [NUM_SENSORS-1:0] echo_fall;
  logic                   timed_out;

  sonic_echo_sync #(.WIDTH(NUM_SENSORS)) u_echo_sync (
    .CLOCK_50 (CLOCK_50),
    .reset_n  (reset_n),
    .din      (echo),
    .rise     (echo_rise),
    .fall     (echo_fall)
  );

  assign sel_next  = (sel == IDX_W'(NUM_SENSORS - 1)) ? '0 : sel + 1'b1;
  // The timeout counter keeps running from trigger end through MEASURE.
  assign timed_out = (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      sel       <= '0;
      trigger   <= '0;
      dist_cm   <= '0;
      timeout   <= '0;
      upd       <= 1'b0;
      upd_idx   <= '0;
      phase_cnt <= '0;
      to_cnt    <= '0;
      prescale  <= '0;
      cm_count  <= '0;
    end else begin
      upd <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            state     <= TRIG;
            phase_cnt <= '0;
            trigger   <= NUM_SENSORS'(1) << sel;
          end
        end

        TRIG: begin
          if (phase_cnt == PH_W'(TRIG_CYCLES - 1)) begin
            trigger <= '0;
            to_cnt  <= '0;
            state   <= WAIT_RISE;
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        WAIT_RISE: begin
          to_cnt <= to_cnt + 1'b1;
          if (echo_rise[sel]) begin
            prescale <= '0;
            cm_count <= '0;
            state    <= MEASURE;
          end else if (timed_out) begin
            dist_cm[int'(sel)*DIST_W +: DIST_W] <= NO_ECHO_CM;
            timeout[sel] <= 1'b1;
            upd          <= 1'b1;
            upd_idx      <= sel;
            phase_cnt    <= '0;
            state        <= GAP;
          end
        end

        MEASURE: begin
          to_cnt <= to_cnt + 1'b1;
          // A falling edge takes priority over a coincident timeout.
          if (echo_fall[sel]) begin
            dist_cm[int'(sel)*DIST_W +: DIST_W] <= cm_count;
            timeout[sel] <= 1'b0;
            upd          <= 1'b1;
            upd_idx      <= sel;
            phase_cnt    <= '0;
            state        <= GAP;
          end else if (timed_out) begin
            dist_cm[int'(sel)*DIST_W +: DIST_W] <= NO_ECHO_CM;
            timeout[sel] <= 1'b1;
            upd          <= 1'b1;
            upd_idx      <= sel;
            phase_cnt    <= '0;
            state        <= GAP;
          end else if (prescale == PS_W'(CYC_PER_CM - 1)) begin
            prescale <= '0;
            if (cm_count != MAX_CM) cm_count <= cm_count + 1'b1;
          end else begin
            prescale <= prescale + 1'b1;
          end
        end

        GAP: begin
          if (phase_cnt == PH_W'(GAP_CYCLES - 1)) begin
            sel       <= sel_next;
            phase_cnt <= '0;
            if (enable) begin
              trigger <= NUM_SENSORS'(1) << sel_next;
              state   <= TRIG;
            end else begin
              state <= IDLE;
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sonic_scheduler.sv
// Directed bench for sonic_scheduler: ranging, timeout, round-robin order,
// enable drop, reset mid-ping and cm saturation.
`timescale 1ns/1ps
module tb_sonic_scheduler;

  logic        CLOCK_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        enable   = 1'b0;
  logic [3:0]  echo     = '0;
  logic [3:0]  trigger;
  logic [47:0] dist_cm;
  logic [3:0]  timeout;
  logic        upd;
  logic [1:0]  upd_idx;
  logic        busy;

  logic        enable2  = 1'b0;
  logic [3:0]  echo2    = '0;
  logic [3:0]  trigger2;
  logic [47:0] dist2;
  logic [3:0]  timeout2;
  logic        upd2;
  logic [1:0]  upd_idx2;
  logic        busy2;

  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_dist [4];
  logic [3:0]  exp_to;

  always #10 CLOCK_50 = ~CLOCK_50;

  sonic_scheduler #(
    .NUM_SENSORS(4), .TRIG_CYCLES(4), .CYC_PER_CM(10),
    .TIMEOUT_CYCLES(1000), .GAP_CYCLES(20)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .enable(enable), .echo(echo),
    .trigger(trigger), .dist_cm(dist_cm), .timeout(timeout), .upd(upd),
    .upd_idx(upd_idx), .busy(busy)
  );

  sonic_scheduler #(
    .NUM_SENSORS(4), .TRIG_CYCLES(4), .CYC_PER_CM(10),
    .TIMEOUT_CYCLES(50000), .GAP_CYCLES(20)
  ) dut_sat (
    .CLOCK_50(CLOCK_50), .reset_n(reset_n), .enable(enable2), .echo(echo2),
    .trigger(trigger2), .dist_cm(dist2), .timeout(timeout2), .upd(upd2),
    .upd_idx(upd_idx2), .busy(busy2)
  );

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  // Waits for the next trigger pulse; ok only if it is sensor s alone.
  task automatic wait_trig(input int s, output bit ok);
    bit seen = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (trigger != 4'b0000) begin
        seen = 1'b1;
        ok   = (trigger == 4'(1 << s));
      end
    end
  endtask

  // Counts trigger-high cycles; returns at the first sample with it low.
  task automatic trig_width(input int s, output int hi);
    hi = 1;
    for (int i = 0; i < 100 && trigger[s]; i++) begin
      tick();
      if (trigger[s]) hi++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) tick();
    checks++;
    if (trigger !== 4'b0 || timeout !== 4'b0 || upd !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: trigger=%b timeout=%b upd=%b busy=%b expected all 0",
               trigger, timeout, upd, busy);
    end
    checks++;
    if (dist_cm !== 48'h0 || dist2 !== 48'h0) begin
      errors++;
      $display("FAIL reset_dist: got %h / %h expected 0", dist_cm, dist2);
    end
    reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (busy !== 1'b0 || trigger !== 4'b0) begin
      errors++;
      $display("FAIL idle_no_enable: busy=%b trigger=%b expected 0/0000", busy, trigger);
    end
  endtask

  task automatic do_ping(input int s, input int delay, input int width,
                         input logic [11:0] exp_cm, input bit drop_en);
    bit ok;
    int hi;
    wait_trig(s, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL trig_order s%0d: got trigger=%b expected one-hot sensor %0d", s, trigger, s);
    end
    trig_width(s, hi);
    checks++;
    if (hi != 4) begin
      errors++;
      $display("FAIL trig_width s%0d: got %0d expected 4", s, hi);
    end
    repeat (delay) tick();
    echo[s] = 1'b1;
    if (drop_en) begin
      repeat (10) tick();
      enable = 1'b0;
      repeat (width - 10) tick();
    end else begin
      repeat (width) tick();
    end
    echo[s] = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++;
      if (upd !== (k == 3)) begin
        errors++;
        $display("FAIL upd_latency s%0d clk%0d: got %b expected %b", s, k, upd, k == 3);
      end
    end
    checks++;
    if (upd_idx !== 2'(s)) begin
      errors++;
      $display("FAIL upd_idx s%0d: got %0d expected %0d", s, upd_idx, s);
    end
    exp_dist[s] = exp_cm;
    exp_to[s]   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dist_cm[i*12 +: 12] !== exp_dist[i]) begin
        errors++;
        $display("FAIL slot%0d after ping s%0d: got %0d expected %0d",
                 i, s, dist_cm[i*12 +: 12], exp_dist[i]);
      end
    end
    checks++;
    if (timeout !== exp_to) begin
      errors++;
      $display("FAIL timeout_flags s%0d: got %b expected %b", s, timeout, exp_to);
    end
    tick();
    checks++;
    if (upd !== 1'b0) begin
      errors++;
      $display("FAIL upd_strobe s%0d: got %b expected 0", s, upd);
    end
  endtask

  task automatic test_timeout();
    bit   ok;
    int   hi;
    int   k;
    logic to_before = 1'b1;
    wait_trig(1, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL trig_order s1: got trigger=%b expected 0010", trigger);
    end
    trig_width(1, hi);
    k = 0;
    for (int i = 1; i <= 1100 && k == 0; i++) begin
      if (i == 1000) to_before = timeout[1];
      tick();
      if (upd) k = i;
    end
    checks++;
    if (k != 1000) begin
      errors++;
      $display("FAIL timeout_delay: got %0d clocks expected 1000", k);
    end
    checks++;
    if (to_before !== 1'b0) begin
      errors++;
      $display("FAIL timeout_early: got flag %b one clock early expected 0", to_before);
    end
    exp_dist[1] = 12'd4095;
    exp_to[1]   = 1'b1;
    checks++;
    if (dist_cm[23:12] !== 12'd4095 || timeout !== exp_to || upd_idx !== 2'd1) begin
      errors++;
      $display("FAIL timeout_result: got slot1=%0d timeout=%b idx=%0d expected 4095/%b/1",
               dist_cm[23:12], timeout, upd_idx, exp_to);
    end
    tick();
  endtask

  task automatic test_round_robin();
    do_ping(2, 7, 123, 12'd12, 1'b0);
    do_ping(3, 3, 57, 12'd5, 1'b0);
    do_ping(0, 12, 88, 12'd8, 1'b0);
    do_ping(1, 5, 204, 12'd20, 1'b0);
    do_ping(2, 9, 315, 12'd31, 1'b0);
    do_ping(3, 4, 76, 12'd7, 1'b0);
  endtask

  task automatic test_enable_drop();
    do_ping(0, 6, 149, 12'd14, 1'b0);
    do_ping(1, 8, 68, 12'd6, 1'b0);
    do_ping(2, 4, 93, 12'd9, 1'b1);
    repeat (18) tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_busy: got %b expected 1 on last gap clock", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_gap: got busy=%b expected 0", busy);
    end
    repeat (5) tick();
    checks++;
    if (trigger !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stays_idle: got trigger=%b busy=%b expected 0000/0", trigger, busy);
    end
    enable = 1'b1;
    tick();
    checks++;
    if (trigger !== 4'b1000) begin
      errors++;
      $display("FAIL resume_sel: got trigger=%b expected 1000", trigger);
    end
  endtask

  task automatic test_reset_mid_ping();
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (trigger !== 4'b0) begin
      errors++;
      $display("FAIL reset_trigger: got %b expected 0000", trigger);
    end
    checks++;
    if (dist_cm !== 48'h0 || timeout !== 4'b0 || upd !== 1'b0 || busy !== 1'b0 || upd_idx !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: dist=%h timeout=%b upd=%b busy=%b idx=%0d expected all 0",
               dist_cm, timeout, upd, busy, upd_idx);
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (upd !== 1'b0 || trigger !== 4'b0) begin
        errors++;
        $display("FAIL reset_hold clk%0d: upd=%b trigger=%b expected 0/0000", i, upd, trigger);
      end
    end
    reset_n = 1'b1;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0 || upd !== 1'b0 || dist_cm !== 48'h0) begin
      errors++;
      $display("FAIL post_reset: busy=%b upd=%b dist=%h expected 0", busy, upd, dist_cm);
    end
  endtask

  task automatic test_saturation();
    bit seen = 1'b0;
    enable2 = 1'b1;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      seen = trigger2[0];
    end
    for (int i = 0; i < 50 && trigger2[0]; i++) tick();
    enable2 = 1'b0;
    repeat (10) tick();
    echo2[0] = 1'b1;
    repeat (41000) tick();
    echo2[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      seen = upd2;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL sat_upd: got no upd expected one within 10 clocks");
    end
    checks++;
    if (dist2[11:0] !== 12'd4094 || timeout2[0] !== 1'b0) begin
      errors++;
      $display("FAIL sat_value: got slot0=%0d timeout=%b expected 4094/0", dist2[11:0], timeout2[0]);
    end
    checks++;
    if (dist2[47:12] !== 36'h0) begin
      errors++;
      $display("FAIL sat_others: got %h expected 0", dist2[47:12]);
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) exp_dist[i] = 12'd0;
    exp_to = 4'b0000;
    test_reset();
    enable = 1'b1;
    do_ping(0, 50, 253, 12'd25, 1'b0);
    test_timeout();
    test_round_robin();
    test_enable_drop();
    test_reset_mid_ping();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
